// File: rtl/play_area_dp_if.sv
// Game/video access bundle for the dual-port play-field RAM.
// The game FSM and pixel pipeline drive the master side; the RAM block is the slave.
interface play_area_dp_if #(
    parameter int WIDTH     = 80,
    parameter int HEIGHT    = 60,
    parameter int BIT_DEPTH = 3
);
    localparam int X_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int Y_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    logic                 clear_start;
    logic                 busy;
    logic [X_W-1:0]       g_x;
    logic [Y_W-1:0]       g_y;
    logic                 g_write_enable;
    logic [BIT_DEPTH-1:0] g_write_value;
    logic [BIT_DEPTH-1:0] g_out;
    logic [X_W-1:0]       v_x;
    logic [Y_W-1:0]       v_y;
    logic [BIT_DEPTH-1:0] v_out;

    modport master (
        output clear_start, g_x, g_y, g_write_enable, g_write_value, v_x, v_y,
        input  busy, g_out, v_out
    );

    modport slave (
        input  clear_start, g_x, g_y, g_write_enable, g_write_value, v_x, v_y,
        output busy, g_out, v_out
    );
endinterface

// File: rtl/play_area_dp.sv
// Dual-port play-field RAM: read-before-write game port, read-only video port,
// and a clear sequencer that fills the grid with CLEAR_VALUE after reset or on request.
module play_area_dp #(
    parameter int                   WIDTH       = 80,
    parameter int                   HEIGHT      = 60,
    parameter int                   BIT_DEPTH   = 3,
    parameter logic [BIT_DEPTH-1:0] CLEAR_VALUE = '0
) (
    input  logic           clk,
    input  logic           reset_n,
    play_area_dp_if.slave  bus
);
    localparam int N   = WIDTH * HEIGHT;
    localparam int X_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int Y_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int AW  = (N > 1) ? $clog2(N) : 1;

    localparam logic [X_W:0]  WIDTH_X  = (X_W + 1)'(WIDTH);
    localparam logic [Y_W:0]  HEIGHT_Y = (Y_W + 1)'(HEIGHT);
    localparam logic [AW-1:0] WIDTH_A  = AW'(WIDTH);
    localparam logic [AW-1:0] LAST_A   = AW'(N - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [AW-1:0]        cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic [BIT_DEPTH-1:0] g_out_q, g_out_d;
    logic [BIT_DEPTH-1:0] v_out_q, v_out_d;

    logic [BIT_DEPTH-1:0] ram [N];

    logic                 g_in_range, v_in_range;
    logic [AW-1:0]        g_addr, v_addr;
    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [BIT_DEPTH-1:0] wr_data;

    // Linear address y*WIDTH + x, sized to hold every in-range cell without truncation.
    always_comb begin
        g_in_range = ({1'b0, bus.g_x} < WIDTH_X) && ({1'b0, bus.g_y} < HEIGHT_Y);
        v_in_range = ({1'b0, bus.v_x} < WIDTH_X) && ({1'b0, bus.v_y} < HEIGHT_Y);
        g_addr     = AW'(bus.g_y) * WIDTH_A + AW'(bus.g_x);
        v_addr     = AW'(bus.v_y) * WIDTH_A + AW'(bus.v_x);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        case (state_q)
            ST_CLEAR: begin
                if (cnt_q == LAST_A) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            ST_IDLE: begin
                if (bus.clear_start) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
                busy_d  = 1'b1;
            end
        endcase
    end

    // Single write port: the sequencer owns it while clearing, the game port otherwise.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = g_addr;
        wr_data = bus.g_write_value;
        if (state_q == ST_CLEAR) begin
            wr_en   = 1'b1;
            wr_addr = cnt_q;
            wr_data = CLEAR_VALUE;
        end else if (g_in_range && bus.g_write_enable) begin
            wr_en = 1'b1;
        end
    end

    // Both reads sample the array before this edge's write lands, giving old data on collisions.
    always_comb begin
        g_out_d = '0;
        v_out_d = '0;
        if ((state_q == ST_IDLE) && g_in_range) begin
            g_out_d = ram[g_addr];
        end
        if (v_in_range) begin
            v_out_d = ram[v_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            g_out_q <= '0;
            v_out_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            g_out_q <= g_out_d;
            v_out_q <= v_out_d;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.g_out = g_out_q;
    assign bus.v_out = v_out_q;
endmodule

// File: tb/tb_play_area_dp.sv
// Directed bench for play_area_dp on a 4x3 grid with CLEAR_VALUE=5.
// Expected values are hand-computed and tracked in a small cell model.
module tb_play_area_dp;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int BD = 3;
    localparam int CV = 5;

    logic clk;
    logic reset_n;

    int n_checks;
    int n_fail;
    int mdl [W*H];
    int n;

    play_area_dp_if #(.WIDTH(W), .HEIGHT(H), .BIT_DEPTH(BD)) bus ();

    play_area_dp #(
        .WIDTH(W), .HEIGHT(H), .BIT_DEPTH(BD), .CLEAR_VALUE(3'(CV))
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic vread(input int x, input int y, input int exp, input string tag);
        bus.v_x = 2'(x);
        bus.v_y = 2'(y);
        tick();
        check(tag, int'(bus.v_out), exp);
    endtask

    task automatic gwrite(input int x, input int y, input int val, input int exp_old, input string tag);
        bus.g_x            = 2'(x);
        bus.g_y            = 2'(y);
        bus.g_write_value  = 3'(val);
        bus.g_write_enable = 1'b1;
        tick();
        bus.g_write_enable = 1'b0;
        check(tag, int'(bus.g_out), exp_old);
    endtask

    task automatic scan_all(input string tag);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                vread(x, y, mdl[y*W + x], $sformatf("%s_v(%0d,%0d)", tag, x, y));
            end
        end
    endtask

    task automatic wait_clear_done(output int edges, input int start);
        edges = start;
        while (bus.busy && edges < 100) begin
            tick();
            edges++;
        end
    endtask

    initial begin
        n_checks           = 0;
        n_fail             = 0;
        reset_n            = 1'b0;
        bus.clear_start    = 1'b0;
        bus.g_x            = '0;
        bus.g_y            = '0;
        bus.g_write_enable = 1'b0;
        bus.g_write_value  = '0;
        bus.v_x            = '0;
        bus.v_y            = '0;
        tick();
        tick();
        check("rst_busy", int'(bus.busy), 1);
        check("rst_g_out", int'(bus.g_out), 0);
        check("rst_v_out", int'(bus.v_out), 0);

        // Power-up clear: 12 edges after release.
        reset_n = 1'b1;
        wait_clear_done(n, 0);
        check("init_clear_edges", n, 12);
        for (int i = 0; i < W*H; i++) mdl[i] = CV;
        scan_all("init");

        // Read-before-write on the game port.
        gwrite(2, 1, 3, 5, "g_wr3_old");
        mdl[6] = 3;
        gwrite(2, 1, 6, 3, "g_wr6_old");
        mdl[6] = 6;
        vread(2, 1, 6, "v_after_wr");
        gwrite(3, 2, 1, 5, "g_wr_last_old");
        mdl[11] = 1;

        // Out-of-range coordinates (row 3 does not exist).
        gwrite(1, 3, 7, 0, "g_oor_wr");
        scan_all("oor");
        vread(0, 3, 0, "v_oor");

        // Re-clear from IDLE; game writes attempted while busy must vanish.
        bus.clear_start = 1'b1;
        tick();
        bus.clear_start = 1'b0;
        check("clr_busy_start", int'(bus.busy), 1);
        bus.g_x            = 2'd0;
        bus.g_y            = 2'd0;
        bus.g_write_value  = 3'd7;
        bus.g_write_enable = 1'b1;
        tick();
        check("clr_g_out_busy", int'(bus.g_out), 0);
        wait_clear_done(n, 2);
        bus.g_write_enable = 1'b0;
        check("clr_edges", n, 13);
        for (int i = 0; i < W*H; i++) mdl[i] = CV;
        scan_all("clr");

        // clear_start in the middle of a clear is ignored.
        bus.clear_start = 1'b1;
        tick();
        bus.clear_start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        bus.clear_start = 1'b1;
        tick();
        bus.clear_start = 1'b0;
        wait_clear_done(n, 8);
        check("ign_start_edges", n, 13);

        // Reset mid-clear takes effect at once and restarts the clear.
        bus.v_x = 2'd0;
        bus.v_y = 2'd0;
        bus.clear_start = 1'b1;
        tick();
        bus.clear_start = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("mid_busy", int'(bus.busy), 1);
        check("mid_v_out", int'(bus.v_out), 5);
        reset_n = 1'b0;
        #1;
        check("async_busy", int'(bus.busy), 1);
        check("async_g_out", int'(bus.g_out), 0);
        check("async_v_out", int'(bus.v_out), 0);
        tick();
        tick();
        reset_n = 1'b1;
        wait_clear_done(n, 0);
        check("restart_edges", n, 12);

        // Same-edge game write and video read of one cell.
        bus.g_x            = 2'd1;
        bus.g_y            = 2'd1;
        bus.g_write_value  = 3'd2;
        bus.g_write_enable = 1'b1;
        bus.v_x            = 2'd1;
        bus.v_y            = 2'd1;
        tick();
        bus.g_write_enable = 1'b0;
        check("coll_v_old", int'(bus.v_out), 5);
        check("coll_g_old", int'(bus.g_out), 5);
        tick();
        check("coll_v_new", int'(bus.v_out), 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
